// File: rtl/y86_mem_bridge.sv
// Y86 memory-stage bus master: one word read/write per request, split into BUS_W beats (little-endian).
// Latency 1+BEATS+1 cycles at zero wait; stall_o holds the pipeline until DONE/ERR; per-beat ack timeout.
module y86_mem_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BUS_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [BUS_W-1:0]  bus_wdata_o,
  input  logic [BUS_W-1:0]  bus_rdata_i,
  input  logic              bus_ack_i
);

  localparam int BEATS  = DATA_W / BUS_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int STRIDE = BUS_W / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [15:0]       TO_LAST   = 16'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [BEAT_W-1:0] beat;
  logic [15:0]       toCnt;
  logic [ADDR_W-1:0] baseAddr;
  logic [DATA_W-1:0] wrData;
  logic [DATA_W-1:0] rdData;
  logic              isWrite;

  logic              inXfer;
  logic              reqAny;
  logic              reqOne;
  logic              reqBoth;
  logic [ADDR_W-1:0] beatOffset;

  assign inXfer  = (state == XFER);
  assign reqAny  = req_read_i | req_write_i;
  assign reqOne  = req_read_i ^ req_write_i;
  assign reqBoth = req_read_i & req_write_i;

  // Beat address wraps modulo 2^ADDR_W by plain truncation.
  assign beatOffset = ADDR_W'(beat) * ADDR_W'(STRIDE);

  assign stall_o     = inXfer | ((state == IDLE) & reqAny);
  assign done_o      = (state == DONE);
  assign err_o       = (state == ERR);
  assign rdata_o     = rdData;
  assign bus_req_o   = inXfer;
  assign bus_we_o    = inXfer & isWrite;
  assign bus_addr_o  = inXfer ? (baseAddr + beatOffset) : '0;
  assign bus_wdata_o = inXfer ? wrData[beat*BUS_W +: BUS_W] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      beat     <= '0;
      toCnt    <= '0;
      baseAddr <= '0;
      wrData   <= '0;
      rdData   <= '0;
      isWrite  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqOne) begin
            baseAddr <= req_addr_i;
            wrData   <= req_data_i;
            isWrite  <= req_write_i;
            beat     <= '0;
            toCnt    <= '0;
            state    <= XFER;
          end else if (reqBoth) begin
            state <= ERR;
          end
        end
        XFER: begin
          if (bus_ack_i) begin
            if (!isWrite) begin
              rdData[beat*BUS_W +: BUS_W] <= bus_rdata_i;
            end
            toCnt <= '0;
            if (beat == LAST_BEAT) begin
              state <= DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end else if (toCnt == TO_LAST) begin
            // Captured read lanes and completed write beats are kept as-is.
            state <= ERR;
          end else begin
            toCnt <= toCnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_mem_bridge.sv
// Directed bench for y86_mem_bridge: 8-bit bus instance (TIMEOUT=4) plus a 16-bit bus instance.
module tb_y86_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;

  logic        reqRead, reqWrite;
  logic [31:0] reqAddr, reqData;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        busReq, busWe;
  logic [31:0] busAddr;
  logic [7:0]  busWdata, busRdata;
  logic        busAck;

  logic        reqRead2, reqWrite2;
  logic [31:0] reqAddr2, reqData2;
  logic        stall2, done2, err2;
  logic [31:0] rdata2;
  logic        busReq2, busWe2;
  logic [31:0] busAddr2;
  logic [15:0] busWdata2, busRdata2;
  logic        busAck2;

  int nChk  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  y86_mem_bridge #(.ADDR_W(32), .DATA_W(32), .BUS_W(8), .TIMEOUT(4)) u8 (
    .clk(clk), .rst(rst),
    .req_read_i(reqRead), .req_write_i(reqWrite), .req_addr_i(reqAddr), .req_data_i(reqData),
    .stall_o(stall), .done_o(done), .err_o(err), .rdata_o(rdata),
    .bus_req_o(busReq), .bus_we_o(busWe), .bus_addr_o(busAddr), .bus_wdata_o(busWdata),
    .bus_rdata_i(busRdata), .bus_ack_i(busAck)
  );

  y86_mem_bridge #(.ADDR_W(32), .DATA_W(32), .BUS_W(16), .TIMEOUT(4)) u16 (
    .clk(clk), .rst(rst),
    .req_read_i(reqRead2), .req_write_i(reqWrite2), .req_addr_i(reqAddr2), .req_data_i(reqData2),
    .stall_o(stall2), .done_o(done2), .err_o(err2), .rdata_o(rdata2),
    .bus_req_o(busReq2), .bus_we_o(busWe2), .bus_addr_o(busAddr2), .bus_wdata_o(busWdata2),
    .bus_rdata_i(busRdata2), .bus_ack_i(busAck2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Zero-wait read on the 8-bit instance; bytesLE supplies beat data lane by lane.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] bytesLE,
                         output int stallCnt, output int doneCnt, output int doneAt,
                         output int badAddr, output int beats);
    logic [31:0] expAddr;
    stallCnt = 0; doneCnt = 0; doneAt = -1; badAddr = 0; beats = 0;
    tick;
    reqRead = 1'b1;
    reqAddr = addr;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) reqRead = 1'b0;
      busAck   = 1'b0;
      busRdata = 8'h00;
      #1;
      if (busReq) begin
        expAddr = addr + 32'(beats);
        if (busAddr !== expAddr) badAddr++;
        if (beats < 4) begin
          busAck   = 1'b1;
          busRdata = bytesLE[8*beats +: 8];
        end
        beats++;
      end
      stallCnt += int'(stall);
      if (done) begin
        doneCnt++;
        doneAt = c;
      end
      tick;
    end
    busAck = 1'b0;
  endtask

  task automatic test_reset;
    int active;
    rst = 1'b0;
    repeat (3) tick;
    nChk++;
    if ({stall, done, err, busReq, busWe} !== 5'b0) begin
      nFail++; $display("FAIL reset_ctrl: got %b want 00000", {stall, done, err, busReq, busWe});
    end
    nChk++;
    if (rdata !== 32'h0) begin nFail++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
    nChk++;
    if ({busAddr, busWdata} !== 40'h0) begin
      nFail++; $display("FAIL reset_bus: got %h want 0", {busAddr, busWdata});
    end
    nChk++;
    if ({stall2, done2, err2, busReq2, rdata2} !== 36'h0) begin
      nFail++; $display("FAIL reset_u16: got %h want 0", {stall2, done2, err2, busReq2, rdata2});
    end
    rst = 1'b1;
    active = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (busReq || stall || done || err || busReq2) active++;
    end
    nChk++;
    if (active !== 0) begin nFail++; $display("FAIL idle_quiet: got %0d active cycles want 0", active); end
  endtask

  task automatic test_read_aligned;
    int stallCnt, doneCnt, doneAt, badAddr, beats;
    do_read(32'h100, 32'h44332211, stallCnt, doneCnt, doneAt, badAddr, beats);
    nChk++;
    if (badAddr !== 0 || beats !== 4) begin
      nFail++; $display("FAIL read_addr: got bad=%0d beats=%0d want bad=0 beats=4", badAddr, beats);
    end
    nChk++;
    if (rdata !== 32'h44332211) begin nFail++; $display("FAIL read_data: got %h want 44332211", rdata); end
    nChk++;
    if (doneCnt !== 1 || doneAt !== 5) begin
      nFail++; $display("FAIL read_done: got cnt=%0d at=%0d want cnt=1 at=5", doneCnt, doneAt);
    end
    nChk++;
    if (stallCnt !== 5) begin nFail++; $display("FAIL read_stall: got %0d want 5", stallCnt); end
  endtask

  task automatic test_write_wait;
    logic [7:0]  wb [4];
    logic [31:0] expAddr;
    int beats, waitCnt, bad, doneCnt, doneAt;
    wb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    beats = 0; waitCnt = 0; bad = 0; doneCnt = 0; doneAt = -1;
    tick;
    reqWrite = 1'b1;
    reqAddr  = 32'h20;
    reqData  = 32'hDEADBEEF;
    for (int c = 0; c < 22; c++) begin
      busAck = 1'b0;
      #1;
      if (busReq) begin
        expAddr = 32'h20 + 32'(beats);
        if (beats > 3) bad++;
        else if (busWe !== 1'b1 || busWdata !== wb[beats] || busAddr !== expAddr) bad++;
        if (waitCnt == 3) begin
          busAck  = 1'b1;
          waitCnt = 0;
          beats++;
        end else begin
          waitCnt++;
        end
      end
      if (done) begin
        doneCnt++;
        doneAt   = c;
        reqWrite = 1'b0;
      end
      tick;
    end
    reqWrite = 1'b0;
    busAck   = 1'b0;
    nChk++;
    if (bad !== 0 || beats !== 4) begin
      nFail++; $display("FAIL write_beats: got bad=%0d beats=%0d want bad=0 beats=4", bad, beats);
    end
    nChk++;
    if (doneCnt !== 1 || doneAt !== 17) begin
      nFail++; $display("FAIL write_done: got cnt=%0d at=%0d want cnt=1 at=17", doneCnt, doneAt);
    end
    nChk++;
    if (rdata !== 32'h44332211) begin nFail++; $display("FAIL write_rdata_kept: got %h want 44332211", rdata); end
  endtask

  task automatic test_timeout;
    int beat1At, errAt, errCnt, doneCnt, reqCnt;
    beat1At = -1; errAt = -1; errCnt = 0; doneCnt = 0; reqCnt = 0;
    tick;
    reqRead = 1'b1;
    reqAddr = 32'h40;
    for (int c = 0; c < 10; c++) begin
      busAck   = 1'b0;
      busRdata = 8'h00;
      #1;
      if (busReq) begin
        reqCnt++;
        if (busAddr === 32'h40) begin
          busAck   = 1'b1;
          busRdata = 8'hA5;
        end
        if (busAddr === 32'h41 && beat1At < 0) beat1At = c;
      end
      if (err) begin
        errCnt++;
        errAt   = c;
        reqRead = 1'b0;
      end
      if (done) doneCnt++;
      tick;
    end
    reqRead = 1'b0;
    busAck  = 1'b0;
    nChk++;
    if (errCnt !== 1 || errAt - beat1At !== 4) begin
      nFail++; $display("FAIL timeout_err: got cnt=%0d delay=%0d want cnt=1 delay=4", errCnt, errAt - beat1At);
    end
    nChk++;
    if (reqCnt !== 5 || doneCnt !== 0) begin
      nFail++; $display("FAIL timeout_bus: got req=%0d done=%0d want req=5 done=0", reqCnt, doneCnt);
    end
    nChk++;
    if (rdata !== 32'h443322A5) begin nFail++; $display("FAIL timeout_rdata: got %h want 443322a5", rdata); end
  endtask

  task automatic test_illegal;
    int errCnt, errAt, reqSeen;
    logic stall0;
    errCnt = 0; errAt = -1; reqSeen = 0; stall0 = 1'b0;
    tick;
    reqRead  = 1'b1;
    reqWrite = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (busReq) reqSeen++;
      if (err) begin
        errCnt++;
        errAt = c;
      end
      if (c == 0) stall0 = stall;
      if (c == 1) begin
        reqRead  = 1'b0;
        reqWrite = 1'b0;
      end
      tick;
    end
    nChk++;
    if (errCnt !== 1 || errAt !== 1) begin
      nFail++; $display("FAIL illegal_err: got cnt=%0d at=%0d want cnt=1 at=1", errCnt, errAt);
    end
    nChk++;
    if (reqSeen !== 0 || stall0 !== 1'b1) begin
      nFail++; $display("FAIL illegal_bus: got req=%0d stall=%b want req=0 stall=1", reqSeen, stall0);
    end
    nChk++;
    if (rdata !== 32'h443322A5) begin nFail++; $display("FAIL illegal_rdata: got %h want 443322a5", rdata); end
  endtask

  task automatic test_wrap;
    int stallCnt, doneCnt, doneAt, badAddr, beats;
    do_read(32'hFFFFFFFE, 32'h04030201, stallCnt, doneCnt, doneAt, badAddr, beats);
    nChk++;
    if (badAddr !== 0 || beats !== 4) begin
      nFail++; $display("FAIL wrap_addr: got bad=%0d beats=%0d want bad=0 beats=4", badAddr, beats);
    end
    nChk++;
    if (rdata !== 32'h04030201 || doneCnt !== 1) begin
      nFail++; $display("FAIL wrap_data: got %h done=%0d want 04030201 done=1", rdata, doneCnt);
    end
  endtask

  task automatic test_reset_midop;
    int stallCnt, doneCnt, doneAt, badAddr, beats;
    tick;
    reqWrite = 1'b1;
    reqAddr  = 32'h80;
    reqData  = 32'h11223344;
    for (int c = 0; c < 3; c++) begin
      busAck = 1'b0;
      #1;
      busAck = busReq;
      tick;
    end
    busAck = 1'b0;
    #1;
    nChk++;
    if (busReq !== 1'b1 || busAddr !== 32'h82 || busWdata !== 8'h22) begin
      nFail++; $display("FAIL midop_beat2: got req=%b addr=%h wd=%h want 1 00000082 22", busReq, busAddr, busWdata);
    end
    rst = 1'b0;
    #1;
    nChk++;
    if ({busReq, busWe, busAddr} !== 34'h0) begin
      nFail++; $display("FAIL midop_drop: got req=%b we=%b addr=%h want 0 0 0", busReq, busWe, busAddr);
    end
    reqWrite = 1'b0;
    tick;
    rst = 1'b1;
    do_read(32'h10, 32'h8D7C6B5A, stallCnt, doneCnt, doneAt, badAddr, beats);
    nChk++;
    if (rdata !== 32'h8D7C6B5A || doneCnt !== 1 || badAddr !== 0 || stallCnt !== 5) begin
      nFail++; $display("FAIL midop_reread: got %h done=%0d bad=%0d stall=%0d want 8d7c6b5a 1 0 5",
                        rdata, doneCnt, badAddr, stallCnt);
    end
  endtask

  task automatic test_bus16;
    logic [31:0] expAddr;
    int beats, bad, stallCnt, doneCnt;
    beats = 0; bad = 0; stallCnt = 0; doneCnt = 0;
    tick;
    reqRead2 = 1'b1;
    reqAddr2 = 32'h200;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) reqRead2 = 1'b0;
      busAck2   = 1'b0;
      busRdata2 = 16'h0;
      #1;
      if (busReq2) begin
        expAddr = 32'h200 + 32'(2 * beats);
        if (busAddr2 !== expAddr) bad++;
        busAck2   = 1'b1;
        busRdata2 = (beats == 0) ? 16'hBEEF : 16'hCAFE;
        beats++;
      end
      stallCnt += int'(stall2);
      if (done2) doneCnt++;
      tick;
    end
    busAck2 = 1'b0;
    nChk++;
    if (bad !== 0 || beats !== 2) begin
      nFail++; $display("FAIL bus16_addr: got bad=%0d beats=%0d want bad=0 beats=2", bad, beats);
    end
    nChk++;
    if (rdata2 !== 32'hCAFEBEEF) begin nFail++; $display("FAIL bus16_data: got %h want cafebeef", rdata2); end
    nChk++;
    if (stallCnt !== 3 || doneCnt !== 1) begin
      nFail++; $display("FAIL bus16_timing: got stall=%0d done=%0d want stall=3 done=1", stallCnt, doneCnt);
    end
  endtask

  initial begin
    rst = 1'b0;
    reqRead = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqData = '0;
    busRdata = '0; busAck = 1'b0;
    reqRead2 = 1'b0; reqWrite2 = 1'b0; reqAddr2 = '0; reqData2 = '0;
    busRdata2 = '0; busAck2 = 1'b0;

    test_reset;
    test_read_aligned;
    test_write_wait;
    test_timeout;
    test_illegal;
    test_wrap;
    test_reset_midop;
    test_bus16;

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
